host_reader: RTL and testbench
==============================

// Module: host_reader
// PURPOSE
// Host-side master for the readout module's host port. On a trigger it pulses START, holds SEL and
// waits for BUSY to rise and then fall. It then latches HNHIT and walks HADDR through the hit buffer.
// Captured HDATA words are streamed out on a ready/valid interface. Sits between the readout block and the DAQ link.
// PARAMETERS
// START_LEN   2     cycles START is held high (readout samples START once per CLK)
// RISE_TMO    16    max cycles from START falling edge to BUSY high, else error
// SCAN_TMO    1023  max cycles BUSY may stay high, else error
// READ_LAT    1     cycles from HADDR change (SEL=1) to valid HDATA
// PORTS
// CLK        in   1   clock, all logic on posedge
// RST_N      in   1   synchronous reset, active low
// TRIG       in   1   scan request, sampled in IDLE only
// START      out  1   start to readout
// SEL        out  1   host select to readout
// HADDR      out  8   buffer read address
// BUSY       in   1   readout running; valid only while SEL=1
// HNHIT      in   9   hit count; valid only while SEL=1
// HDATA      in   24  {addr[7:0],data[15:0]} from buffer
// OUT_VALID  out  1   stream word valid
// OUT_READY  in   1   downstream accept
// OUT_DATA   out  24  stream word
// OUT_LAST   out  1   marks final word of event
// DONE       out  1   one-cycle pulse at event end (also on error)
// ERR        out  2   sticky until next TRIG accepted: 01 rise timeout, 10 scan timeout, 11 count clamped
// BEHAVIOUR
// - Reset: all outputs 0, HADDR=0, state IDLE. RST_N low mid-event aborts immediately; no DONE is issued.
// - States: IDLE -> STRT -> WRISE -> WFALL -> LATCH -> HDR -> ADDR -> WAIT -> EMIT -> (ADDR|TRL|FIN) -> IDLE.
// - IDLE: TRIG=1 clears ERR and goes to STRT. TRIG is ignored in every other state (not queued).
// - STRT: START=1 for START_LEN cycles. SEL=1 from STRT until FIN inclusive.
// - WRISE: wait for BUSY=1. If RISE_TMO cycles elapse first: ERR=01, go to FIN (no stream output).
// - WFALL: wait for BUSY=0. If SCAN_TMO cycles elapse first: ERR=10, go to FIN.
// - LATCH: N = HNHIT registered. If N>256: N clamped to 256, ERR=11 (buffer depth is 256).
// - HDR: header word {15'b0,HNHIT raw}; OUT_LAST=1 if N=0 and trailer is disabled.
// - ADDR/WAIT: drive HADDR=i, wait READ_LAT cycles, capture HDATA. i runs 0..N-1.
// - EMIT: present the captured word. OUT_LAST=1 on i=N-1 when trailer is disabled.
// - Stream rules: OUT_DATA/OUT_LAST held stable while OUT_VALID=1 && OUT_READY=0. Transfer occurs on VALID&&READY.
// - Stream rules: no new read is issued until the current word transfers (1-deep holding register).
// - Full-speed (READY=1): one word every READ_LAT+2 cycles.
// - The header is always emitted, including when N=0.
// - HADDR is 8-bit. i=255 is the last read when N=256; no wrap-around to 0 is issued.
// - FIN: DONE=1 for one cycle, then IDLE. SEL drops in IDLE.
// - Timers share one counter; it is reset on every state entry.
// CONFIGURATION
// HOST_READER_TRAILER_EN defined:
//   after the last data word (or after the header if N=0), emit trailer {8'hA5, 16-bit XOR of data[15:0] of all words}.
//   The trailer carries OUT_LAST=1. The XOR of zero words is 16'h0000.
// HOST_READER_TRAILER_EN undefined: no trailer; OUT_LAST rides on the last data word, or on the header if N=0.
// STRUCTURE
// host_reader_pkg:
//   state encoding localparams; widths ADDR_W=8, DATA_W=16, NHIT_W=9, WORD_W=24;
//   MAX_HITS=256; ERR_* codes; TRAILER_TAG=8'hA5.
// Sub-module host_reader_timer: loadable down-counter with terminal flag, used for START_LEN, READ_LAT and both timeouts.
// TESTING
// 1. TRIG pulse; model BUSY high 3 cycles after START, for 256 cycles; HNHIT=3; READY=1
//    -> START high 2 cycles; header 0x000003; HADDR 0,1,2 read in order; 3 HDATA words; OUT_LAST on word 3; one DONE.
// 2. HNHIT=0 -> only header 0x000000, OUT_LAST=1. With TRAILER_EN: header, then 0xA50000 with OUT_LAST.
// 3. BUSY never rises -> DONE 16 cycles after START falls; ERR=01; OUT_VALID never asserted; SEL=0 afterwards.
// 4. HNHIT=300 -> header 0x00012C; exactly 256 data words (HADDR 0..255); ERR=11.
// 5. READY toggled randomly with HNHIT=5 -> no word lost or duplicated; OUT_DATA stable while stalled; TRIG mid-event ignored.
// 6. RST_N low during EMIT -> all outputs 0 next cycle; no DONE. A fresh TRIG then yields a complete event.

Source files
------------

// File: rtl/host_reader_pkg.sv
// host_reader_pkg
// Shared widths, timing constants, error codes and state encoding for the
// host-side readout master (host_reader) and its timer.
// Build option: HOST_READER_TRAILER_EN (used by host_reader) appends a trailer
// word to every event.
package host_reader_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int NHIT_W = 9;
    localparam int WORD_W = 24;
    localparam int TMR_W  = 10;

    // The readout buffer holds 256 entries; larger hit counts are clamped.
    localparam logic [NHIT_W-1:0] MAX_HITS = 9'd256;

    localparam int START_LEN = 2;
    localparam int RISE_TMO  = 16;
    localparam int SCAN_TMO  = 1023;
    localparam int READ_LAT  = 1;

    // The timer counts down to zero and flags terminal on zero, so a wait of
    // L cycles is loaded as L-1.
    localparam logic [TMR_W-1:0] START_LOAD = TMR_W'(START_LEN - 1);
    localparam logic [TMR_W-1:0] RISE_LOAD  = TMR_W'(RISE_TMO - 1);
    localparam logic [TMR_W-1:0] SCAN_LOAD  = TMR_W'(SCAN_TMO - 1);
    localparam logic [TMR_W-1:0] READ_LOAD  = TMR_W'(READ_LAT - 1);

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RISE  = 2'b01;
    localparam logic [1:0] ERR_SCAN  = 2'b10;
    localparam logic [1:0] ERR_CLAMP = 2'b11;

    localparam logic [7:0] TRAILER_TAG = 8'hA5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_STRT,
        S_WRISE,
        S_WFALL,
        S_LATCH,
        S_HDR,
        S_ADDR,
        S_WAIT,
        S_EMIT,
        S_TRL,
        S_FIN
    } state_t;

    function automatic logic [NHIT_W-1:0] clamp_hits(input logic [NHIT_W-1:0] raw);
        return (raw > MAX_HITS) ? MAX_HITS : raw;
    endfunction

endpackage

// File: rtl/host_reader_if.sv
// host_reader_if
// Bundles the readout host port (start/sel/haddr/busy/hnhit/hdata) and the
// outgoing ready/valid stream (out_valid/out_ready/out_data/out_last).
// master : host_reader side; slave : readout block plus stream consumer.
interface host_reader_if;
    import host_reader_pkg::*;

    logic              start;
    logic              sel;
    logic [ADDR_W-1:0] haddr;
    logic              busy;
    logic [NHIT_W-1:0] hnhit;
    logic [WORD_W-1:0] hdata;

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;

    modport master (
        output start, sel, haddr, out_valid, out_data, out_last,
        input  busy, hnhit, hdata, out_ready
    );

    modport slave (
        input  start, sel, haddr, out_valid, out_data, out_last,
        output busy, hnhit, hdata, out_ready
    );

endinterface

// File: rtl/host_reader_timer.sv
// host_reader_timer
// Loadable down-counter shared by all of host_reader's waits.
// Ports: clk, rst_n (sync, active low), load, load_val, tc (count is zero).
module host_reader_timer
    import host_reader_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             tc
);

    logic [TMR_W-1:0] count;

    // Load wins over counting; the counter parks at zero once expired.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/host_reader.sv
// host_reader
// Host-side master for the readout host port. A trigger starts a scan; once
// the readout finishes, the hit buffer is read out and streamed as
// header, data words (and optionally a trailer) on a ready/valid interface.
// Ports: clk, rst_n (sync, active low), trig, bus (host_reader_if.master),
//        done (one-cycle end-of-event pulse), err (sticky error code).
// Build option: HOST_READER_TRAILER_EN adds a trailer {A5, XOR of data}.
module host_reader
    import host_reader_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          trig,
    host_reader_if.master bus,
    output logic          done,
    output logic [1:0]    err
);

`ifdef HOST_READER_TRAILER_EN
    localparam logic   TRAILER_ON = 1'b1;
    localparam state_t AFTER_LAST = S_TRL;
`else
    localparam logic   TRAILER_ON = 1'b0;
    localparam state_t AFTER_LAST = S_FIN;
`endif

    state_t            state;
    state_t            state_next;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_tc;
    logic [NHIT_W-1:0] raw_hits;
    logic [NHIT_W-1:0] n_hits;
    logic [ADDR_W-1:0] idx;
    logic [WORD_W-1:0] word_q;
    logic              last_word;
`ifdef HOST_READER_TRAILER_EN
    logic [DATA_W-1:0] xor_q;
`endif

    // Every state change restarts the shared timer.
    host_reader_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    assign tmr_load  = (state_next != state);
    assign last_word = ({1'b0, idx} == (n_hits - 9'd1));
    assign bus.haddr = idx;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, port outputs and the timer reload value for the next state.
    always_comb begin
        state_next    = state;
        tmr_val       = '0;
        bus.start     = 1'b0;
        bus.sel       = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        done          = 1'b0;

        case (state)
            S_IDLE: begin
                if (trig) state_next = S_STRT;
            end
            S_STRT: begin
                bus.start = 1'b1;
                bus.sel   = 1'b1;
                if (tmr_tc) state_next = S_WRISE;
            end
            S_WRISE: begin
                bus.sel = 1'b1;
                if (bus.busy)    state_next = S_WFALL;
                else if (tmr_tc) state_next = S_FIN;
            end
            S_WFALL: begin
                bus.sel = 1'b1;
                if (!bus.busy)   state_next = S_LATCH;
                else if (tmr_tc) state_next = S_FIN;
            end
            S_LATCH: begin
                bus.sel    = 1'b1;
                state_next = S_HDR;
            end
            S_HDR: begin
                bus.sel       = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_data  = {15'b0, raw_hits};
                bus.out_last  = (n_hits == '0) && !TRAILER_ON;
                if (bus.out_ready) begin
                    state_next = (n_hits == '0) ? AFTER_LAST : S_ADDR;
                end
            end
            S_ADDR: begin
                bus.sel    = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                bus.sel = 1'b1;
                if (tmr_tc) state_next = S_EMIT;
            end
            S_EMIT: begin
                bus.sel       = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_data  = word_q;
                bus.out_last  = last_word && !TRAILER_ON;
                if (bus.out_ready) begin
                    state_next = last_word ? AFTER_LAST : S_ADDR;
                end
            end
`ifdef HOST_READER_TRAILER_EN
            S_TRL: begin
                bus.sel       = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_data  = {TRAILER_TAG, xor_q};
                bus.out_last  = 1'b1;
                if (bus.out_ready) state_next = S_FIN;
            end
`endif
            S_FIN: begin
                bus.sel    = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        case (state_next)
            S_STRT:  tmr_val = START_LOAD;
            S_WRISE: tmr_val = RISE_LOAD;
            S_WFALL: tmr_val = SCAN_LOAD;
            S_WAIT:  tmr_val = READ_LOAD;
            default: tmr_val = '0;
        endcase
    end

    // Event datapath: error code, hit count, read index and the holding
    // register. The index only advances after the held word is accepted, so
    // the last read address is N-1 and never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err      <= ERR_NONE;
            raw_hits <= '0;
            n_hits   <= '0;
            idx      <= '0;
            word_q   <= '0;
`ifdef HOST_READER_TRAILER_EN
            xor_q    <= '0;
`endif
        end else begin
            if (state == S_IDLE && trig) begin
                err <= ERR_NONE;
            end
            if (state == S_WRISE && !bus.busy && tmr_tc) begin
                err <= ERR_RISE;
            end
            if (state == S_WFALL && bus.busy && tmr_tc) begin
                err <= ERR_SCAN;
            end
            if (state == S_LATCH) begin
                raw_hits <= bus.hnhit;
                n_hits   <= clamp_hits(bus.hnhit);
                idx      <= '0;
`ifdef HOST_READER_TRAILER_EN
                xor_q    <= '0;
`endif
                if (bus.hnhit > MAX_HITS) begin
                    err <= ERR_CLAMP;
                end
            end
            if (state == S_WAIT && tmr_tc) begin
                word_q <= bus.hdata;
`ifdef HOST_READER_TRAILER_EN
                xor_q  <= xor_q ^ bus.hdata[DATA_W-1:0];
`endif
            end
            if (state == S_EMIT && bus.out_ready && !last_word) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_host_reader.sv
// tb_host_reader
// Self-checking bench for host_reader. A negedge process models the readout
// block (BUSY profile, one-cycle-latency buffer reads), drives OUT_READY and
// compares every accepted stream word against a queue of expected words
// computed from the hit count and buffer contents.
module tb_host_reader;
    import host_reader_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       trig  = 1'b0;
    logic       done;
    logic [1:0] err;

    host_reader_if bus();

    host_reader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .trig  (trig),
        .bus   (bus.master),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

`ifdef HOST_READER_TRAILER_EN
    localparam int TRL = 1;
`else
    localparam int TRL = 0;
`endif

    logic [15:0] mem [256];
    logic [23:0] exp_data [$];
    logic        exp_last [$];
    logic [23:0] got_data [$];
    logic        got_last [$];

    int n_compared   = 0;
    int n_mismatch   = 0;
    int cyc          = 0;
    int start_events = 0;
    int start_run    = 0;
    int fall_stamp   = 0;
    int done_stamp   = 0;
    int done_cnt     = 0;
    int valid_cycles = 0;
    int xfer_count   = 0;
    int ready_mode   = 0;
    int rise_delay   = 3;
    int busy_len     = 256;
    bit never_rise   = 1'b0;

    logic [7:0]  prev_haddr = 8'h00;
    logic        start_prev = 1'b0;
    logic        prev_stall = 1'b0;
    logic [23:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    logic        armed      = 1'b0;
    logic        busy_hi    = 1'b0;
    int          rise_cnt   = 0;
    int          busy_cnt   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Readout model, ready generator and stream scoreboard.
    always @(negedge clk) begin
        cyc++;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = (xfer_count == 0);
        endcase
        bus.hdata  = {prev_haddr, mem[prev_haddr]};
        prev_haddr = bus.haddr;

        if (!rst_n) begin
            prev_stall = 1'b0;
            start_prev = 1'b0;
            start_run  = 0;
            armed      = 1'b0;
            busy_hi    = 1'b0;
        end else begin
            if (bus.start && !start_prev) begin
                rise_cnt = rise_delay;
                armed    = !never_rise;
            end else if (armed) begin
                if (rise_cnt > 1) rise_cnt--;
                else begin
                    armed    = 1'b0;
                    busy_hi  = 1'b1;
                    busy_cnt = busy_len;
                end
            end else if (busy_hi) begin
                if (busy_cnt > 1) busy_cnt--;
                else busy_hi = 1'b0;
            end

            if (bus.start) begin
                if (!start_prev) start_events++;
                start_run++;
            end else if (start_prev) begin
                checkOutput("start_len", start_run, START_LEN);
                start_run  = 0;
                fall_stamp = cyc;
            end
            start_prev = bus.start;

            if (done) begin
                done_cnt++;
                done_stamp = cyc;
            end
            if (bus.out_valid) valid_cycles++;

            if (prev_stall) begin
                checkOutput("stall_valid", 32'(bus.out_valid), 1);
                checkOutput("stall_data", 32'(bus.out_data), 32'(prev_data));
                checkOutput("stall_last", 32'(bus.out_last), 32'(prev_last));
            end

            if (bus.out_valid && bus.out_ready) begin
                if (exp_data.size() == 0) begin
                    n_compared++;
                    n_mismatch++;
                    $display("[TB] FAIL extra_word: got 0x%0h expected no word", bus.out_data);
                end else begin
                    checkOutput("word_data", 32'(bus.out_data), 32'(exp_data.pop_front()));
                    checkOutput("word_last", 32'(bus.out_last), 32'(exp_last.pop_front()));
                end
                got_data.push_back(bus.out_data);
                got_last.push_back(bus.out_last);
                xfer_count++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
        bus.busy = busy_hi;
    end

    // Expected stream for one event, computed from the hit count alone.
    task automatic buildModel(input logic [8:0] nhit);
        int          n;
        logic [15:0] x;
        n = (nhit > 9'd256) ? 256 : int'(nhit);
        x = 16'h0000;
        exp_data.push_back({15'b0, nhit});
        exp_last.push_back((n == 0) && (TRL == 0));
        for (int i = 0; i < n; i++) begin
            exp_data.push_back({8'(i), mem[i]});
            exp_last.push_back((i == n - 1) && (TRL == 0));
            x = x ^ mem[i];
        end
        if (TRL == 1) begin
            exp_data.push_back({8'hA5, x});
            exp_last.push_back(1'b1);
        end
    endtask

    task automatic pulseTrig();
        @(negedge clk) trig = 1'b1;
        @(negedge clk) trig = 1'b0;
    endtask

    task automatic applyStimulus(input logic [8:0] nhit, input bit no_rise, input int rmode);
        bus.hnhit  = nhit;
        never_rise = no_rise;
        ready_mode = rmode;
        exp_data.delete();
        exp_last.delete();
        got_data.delete();
        got_last.delete();
        done_cnt     = 0;
        start_events = 0;
        valid_cycles = 0;
        xfer_count   = 0;
        if (!no_rise) buildModel(nhit);
        pulseTrig();
    endtask

    task automatic waitDone(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL %s_timeout: got no DONE expected DONE within 4000 cycles", name);
        end
        @(negedge clk);
    endtask

    task automatic checkEvent(input string name, input logic [1:0] exp_err);
        checkOutput({name, "_done_count"}, done_cnt, 1);
        checkOutput({name, "_err"}, 32'(err), 32'(exp_err));
        checkOutput({name, "_words_left"}, exp_data.size(), 0);
        checkOutput({name, "_sel_after"}, 32'(bus.sel), 0);
    endtask

    task automatic checkIdleOutputs(input string name);
        checkOutput({name, "_start"}, 32'(bus.start), 0);
        checkOutput({name, "_sel"}, 32'(bus.sel), 0);
        checkOutput({name, "_haddr"}, 32'(bus.haddr), 0);
        checkOutput({name, "_valid"}, 32'(bus.out_valid), 0);
        checkOutput({name, "_data"}, 32'(bus.out_data), 0);
        checkOutput({name, "_last"}, 32'(bus.out_last), 0);
        checkOutput({name, "_done"}, 32'(done), 0);
        checkOutput({name, "_err"}, 32'(err), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end expected end of run");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000 ^ 16'(i * 273);
        bus.hnhit = '0;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: three hits at full speed.
        applyStimulus(9'd3, 1'b0, 0);
        waitDone("t1");
        checkEvent("t1", ERR_NONE);
        checkOutput("t1_words", got_data.size(), 4 + TRL);
        checkOutput("t1_header", 32'(got_data[0]), 32'h000003);
        checkOutput("t1_word0", 32'(got_data[1]), 32'h00C000);
        checkOutput("t1_word2", 32'(got_data[3]), 32'h02C222);
        checkOutput("t1_last_on_word2", 32'(got_last[3]), 32'(TRL == 0));
        checkOutput("t1_start_events", start_events, 1);

        // 2: zero hits -> header only (plus trailer when enabled).
        applyStimulus(9'd0, 1'b0, 0);
        waitDone("t2");
        checkEvent("t2", ERR_NONE);
        checkOutput("t2_words", got_data.size(), 1 + TRL);
        checkOutput("t2_header", 32'(got_data[0]), 32'h000000);
        checkOutput("t2_header_last", 32'(got_last[0]), 32'(TRL == 0));
        if (TRL == 1) checkOutput("t2_trailer", 32'(got_data[1]), 32'hA50000);

        // 3: BUSY never rises.
        applyStimulus(9'd3, 1'b1, 0);
        waitDone("t3");
        checkEvent("t3", ERR_RISE);
        checkOutput("t3_fall_to_done", done_stamp - fall_stamp, 16);
        checkOutput("t3_no_valid", valid_cycles, 0);

        // 4: hit count above buffer depth is clamped.
        applyStimulus(9'd300, 1'b0, 0);
        waitDone("t4");
        checkEvent("t4", ERR_CLAMP);
        checkOutput("t4_header", 32'(got_data[0]), 32'h00012C);
        checkOutput("t4_words", got_data.size(), 257 + TRL);

        // 5: random backpressure and a trigger that lands mid-event.
        applyStimulus(9'd5, 1'b0, 1);
        repeat (8) @(negedge clk);
        pulseTrig();
        waitDone("t5");
        repeat (20) @(negedge clk);
        checkEvent("t5", ERR_NONE);
        checkOutput("t5_words", got_data.size(), 6 + TRL);
        checkOutput("t5_start_events", start_events, 1);

        // 6: reset while a data word is held, then a fresh event.
        applyStimulus(9'd4, 1'b0, 2);
        found = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_data == {8'h00, mem[0]}) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("t6_reached_emit", 32'(found), 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkIdleOutputs("t6_abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("t6_no_done", done_cnt, 0);
        @(negedge clk);
        applyStimulus(9'd4, 1'b0, 0);
        waitDone("t6");
        checkEvent("t6", ERR_NONE);
        checkOutput("t6_words", got_data.size(), 5 + TRL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
